// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter and its helpers.
package dm_arbiter_pkg;
    localparam int unsigned AW_DEF        = 32;
    localparam int unsigned DW_DEF        = 32;
    localparam int unsigned MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the master that did not own last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic winner,
    output logic any
);
    always_comb begin
        any = req0 | req1;
        if (req0 && req1) winner = ~last_owner;
        else              winner = req1;
    end
endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between the CPU
// data port (master 0) and a debug/DMA master (master 1), with bounded bursts.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          dm_ena,
    output logic          dm_wena,
    output logic          dm_rena,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    output logic          busy
);
    localparam int unsigned   CW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    arb_state_e    state, next_state;
    logic [CW-1:0] beat_cnt;
    logic          last_owner;
    logic          pick_winner, pick_any;
    logic          own_sel, own_req, oth_req, own_we, beat;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;

    rr_pick2 u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_owner (last_owner),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    // Owner-selected datapath; every dm_* output is forced to zero without a beat.
    always_comb begin
        own_sel   = (state == OWN1);
        own_req   = own_sel ? m1_req   : m0_req;
        oth_req   = own_sel ? m0_req   : m1_req;
        own_we    = own_sel ? m1_we    : m0_we;
        own_addr  = own_sel ? m1_addr  : m0_addr;
        own_wdata = own_sel ? m1_wdata : m0_wdata;
        beat      = (state != IDLE) && own_req;
        dm_ena    = beat;
        dm_wena   = beat & own_we;
        dm_rena   = beat & ~own_we;
        dm_addr   = beat ? own_addr  : '0;
        dm_wdata  = beat ? own_wdata : '0;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (pick_any) next_state = pick_winner ? OWN1 : OWN0;
            OWN0, OWN1: begin
                if (!own_req)
                    next_state = oth_req ? (own_sel ? OWN0 : OWN1) : IDLE;
                else if (oth_req && beat_cnt == LAST_BEAT)
                    next_state = own_sel ? OWN0 : OWN1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            busy       <= 1'b0;
            beat_cnt   <= '0;
            last_owner <= 1'b1;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            state  <= next_state;
            m0_gnt <= (next_state == OWN0);
            m1_gnt <= (next_state == OWN1);
            busy   <= (next_state != IDLE);

            // Counter saturates so an uncontended owner never wraps back to zero.
            if (state == IDLE || next_state != state)
                beat_cnt <= '0;
            else if (beat && beat_cnt != LAST_BEAT)
                beat_cnt <= beat_cnt + CW'(1);

            if (state != IDLE && next_state != state)
                last_owner <= own_sel;

            m0_rvalid <= beat && !own_we && !own_sel;
            m1_rvalid <= beat && !own_we && own_sel;
            if (beat && !own_we && !own_sel) m0_rdata <= dm_rdata;
            if (beat && !own_we && own_sel)  m1_rdata <= dm_rdata;
        end
    end
endmodule
